// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding imem request, small FIFO to decode
// Flush drops in-flight data (via DISCARD) and empties the FIFO in the same cycle.
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush,
  output logic               pc_hold,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                push, pop;

  logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // pc_in is stale during a flush cycle, so no request is issued then.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < DEPTH_C)) begin
          addr_d  = pc_in;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          push    = !flush;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q != S_IDLE);
  assign imem_addr   = addr_q;
  assign pc_hold     = !((state_q == S_WAIT) && imem_ack && !flush);
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= addr_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Flush outranks any simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with PC-stage and variable-latency memory models
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_in = 16'h0000;
  logic        flush;
  logic        pc_hold;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;

  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] jump_tgt;
  logic [7:0]  lat;
  logic [7:0]  wait_cnt = 8'd0;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  // PC stage: jump overrides hold, otherwise advance when not held.
  always @(posedge clk) begin
    if (pc_load)       pc_in <= pc_load_val;
    else if (flush)    pc_in <= jump_tgt;
    else if (!pc_hold) pc_in <= pc_in + 16'd1;
  end

  // Memory: ack after 'lat' cycles of waiting; data is a fixed function of address.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 8'd0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end
  assign imem_ack   = imem_req && (wait_cnt == lat);
  assign imem_rdata = imem_addr ^ 16'hC3A5;

  function automatic logic [31:0] exp_word(input logic [15:0] pc);
    return {pc, pc ^ 16'hC3A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor samples just before the rising edge on which a pop happens.
  always begin
    logic [31:0] e;
    @(negedge clk);
    #4;
    if (reset && !flush && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", {16'h0, instr_pc}, {16'h0, e[31:16]});
        check("instr_out", {16'h0, instr_out}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [15:0] pcv);
    reset       = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = pcv;
    flush       = 1'b0;
    instr_ready = 1'b0;
    repeat (2) step();
    reset   = 1'b1;
    pc_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, imem_req},    32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_addr"},  {16'h0, imem_addr},   32'h0);
    check({tag, "_out"},   {16'h0, instr_out},   32'h0);
    check({tag, "_pc"},    {16'h0, instr_pc},    32'h0);
  endtask

  task automatic drain();
    int n = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    exp_q.delete();
    instr_ready = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    check(name, {31'h0, imem_req}, 32'h1);
  endtask

  initial begin
    int n;
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_load = 1'b1;
    pc_load_val = 16'h0; jump_tgt = 16'h0; lat = 8'd0;

    // Sequential fetch, zero wait
    apply_reset(16'h0000);
    check_reset_outputs("rst1");
    check("rst1_hold", {31'h0, pc_hold}, 32'h1);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(16'(i)));
    drain();

    // Decode stalled: FIFO fills to two entries, then drains and resumes
    apply_reset(16'h0000);
    repeat (12) step();
    check("full_valid", {31'h0, instr_valid}, 32'h1);
    check("full_noreq", {31'h0, imem_req}, 32'h0);
    check("full_hold", {31'h0, pc_hold}, 32'h1);
    check("full_pc", {16'h0, pc_in}, 32'h0002);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(16'(i)));
    drain();

    // Five-cycle memory latency: request stays stable
    apply_reset(16'h0010);
    lat = 8'd5;
    exp_q.push_back(exp_word(16'h0010));
    exp_q.push_back(exp_word(16'h0011));
    wait_req("lat_req_seen");
    for (int i = 0; i < 5; i++) begin
      check("lat_req_stable", {31'h0, imem_req}, 32'h1);
      check("lat_addr_stable", {16'h0, imem_addr}, 32'h0010);
      step();
    end
    drain();

    // Flush while waiting: DISCARD swallows the late ack
    apply_reset(16'h0020);
    lat = 8'd3;
    n = 0;
    while (!(instr_valid && imem_req) && n < 50) begin step(); n++; end
    check("fl_setup_addr", {16'h0, imem_addr}, 32'h0021);
    flush = 1'b1; jump_tgt = 16'h0040;
    step();
    flush = 1'b0;
    check("fl_fifo_empty", {31'h0, instr_valid}, 32'h0);
    check("fl_discard_req", {31'h0, imem_req}, 32'h1);
    check("fl_discard_addr", {16'h0, imem_addr}, 32'h0021);
    check("fl_new_pc", {16'h0, pc_in}, 32'h0040);
    n = 0;
    while (imem_req && n < 50) begin step(); n++; end
    wait_req("fl_next_req");
    check("fl_next_addr", {16'h0, imem_addr}, 32'h0040);
    exp_q.push_back(exp_word(16'h0040));
    exp_q.push_back(exp_word(16'h0041));
    drain();

    // Flush coincident with ack and pop
    apply_reset(16'h0030);
    lat = 8'd0;
    n = 0;
    while (!(instr_valid && imem_req && imem_ack) && n < 50) begin step(); n++; end
    check("fap_setup_addr", {16'h0, imem_addr}, 32'h0031);
    instr_ready = 1'b1; flush = 1'b1; jump_tgt = 16'h0050;
    exp_q.push_back(exp_word(16'h0050));
    exp_q.push_back(exp_word(16'h0051));
    step();
    flush = 1'b0;
    check("fap_fifo_empty", {31'h0, instr_valid}, 32'h0);
    check("fap_idle", {31'h0, imem_req}, 32'h0);
    wait_req("fap_next_req");
    check("fap_next_addr", {16'h0, imem_addr}, 32'h0050);
    drain();

    // PC wrap-around, then reset in the middle of a wait
    apply_reset(16'hFFFF);
    exp_q.push_back(exp_word(16'hFFFF));
    exp_q.push_back(exp_word(16'h0000));
    drain();
    lat = 8'd5;
    n = 0;
    while (!(imem_req && !imem_ack) && n < 50) begin step(); n++; end
    check("mid_wait_req", {31'h0, imem_req}, 32'h1);
    reset = 1'b0;
    step();
    check_reset_outputs("rst2");
    check("rst2_hold", {31'h0, pc_hold}, 32'h1);
    reset = 1'b1;
    step();
    step();
    check("rst2_no_data", {31'h0, instr_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
